// File: rtl/null_sink_checker.sv
// CHDR null-sink checker: sequence/length checks, counters, throttle.
// Optional cycle timer on rb_addr 4 via NULL_SINK_CHECKER_TIMER_EN.
module null_sink_checker #(
  parameter logic [7:0] SR_ENABLE     = 8'd132,
  parameter logic [7:0] SR_CLEAR_CNT  = 8'd133,
  parameter logic [7:0] SR_READY_RATE = 8'd134
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [7:0]  rb_addr,
  output logic [63:0] rb_data,
  input  logic [63:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic        seq_err,
  output logic        len_err
);

  typedef enum logic {S_HDR, S_BODY} state_t;

  state_t      state;
  logic        enable;
  logic [15:0] rate;
  logic [15:0] thr_cnt;
  logic        seq_valid;
  logic [11:0] exp_seq;
  logic [15:0] beats;
  logic [15:0] exp_beats;
  logic [63:0] pkt_cnt;
  logic [63:0] beat_cnt;
  logic [31:0] seq_err_cnt;
  logic [31:0] len_err_cnt;
  logic [63:0] timer;

  logic        clr;
  logic        accept;
  logic [15:0] hdr_len;
  logic [11:0] hdr_seq;
  logic [16:0] len_sum;
  logic [15:0] hdr_exp;
  logic [15:0] cur_beats;
  logic [15:0] cur_exp;
  logic        is_hdr;
  logic        seq_bad;
  logic        len_bad;
  logic [35:0] status;

  assign clr      = clear | (set_stb & (set_addr == SR_CLEAR_CNT));
  assign i_tready = enable & (thr_cnt == 16'd0);
  assign accept   = i_tvalid & i_tready;

  assign hdr_len  = i_tdata[47:32];
  assign hdr_seq  = i_tdata[59:48];
  assign len_sum  = {1'b0, hdr_len} + 17'd7;
  assign hdr_exp  = (hdr_len < 16'd8) ? 16'd1 : {3'd0, len_sum[16:4], 1'b0} | {15'd0, len_sum[3]};

  assign is_hdr    = (state == S_HDR);
  assign cur_beats = is_hdr ? 16'd1 : beats + 16'd1;
  assign cur_exp   = is_hdr ? hdr_exp : exp_beats;
  assign seq_bad   = accept & is_hdr & seq_valid & (hdr_seq != exp_seq);
  assign len_bad   = accept & i_tlast & (cur_beats != cur_exp);
  assign status    = {33'd0, seq_valid, ~is_hdr, enable};

  // settings registers: enable and throttle rate
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable <= 1'b0;
      rate   <= 16'd0;
    end else if (set_stb) begin
      if (set_addr == SR_ENABLE)     enable <= set_data[0];
      if (set_addr == SR_READY_RATE) rate   <= set_data[15:0];
    end
  end

  // throttle down-counter, reloads rate when it reaches zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               thr_cnt <= 16'd0;
    else if (thr_cnt == 16'd0)  thr_cnt <= rate;
    else                        thr_cnt <= thr_cnt - 16'd1;
  end

  // packet parser, sequence/length checks and counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_HDR;
      seq_valid   <= 1'b0;
      exp_seq     <= 12'd0;
      beats       <= 16'd0;
      exp_beats   <= 16'd0;
      pkt_cnt     <= 64'd0;
      beat_cnt    <= 64'd0;
      seq_err_cnt <= 32'd0;
      len_err_cnt <= 32'd0;
      seq_err     <= 1'b0;
      len_err     <= 1'b0;
    end else if (clr) begin
      state       <= S_HDR;
      seq_valid   <= 1'b0;
      exp_seq     <= 12'd0;
      beats       <= 16'd0;
      exp_beats   <= 16'd0;
      pkt_cnt     <= 64'd0;
      beat_cnt    <= 64'd0;
      seq_err_cnt <= 32'd0;
      len_err_cnt <= 32'd0;
      seq_err     <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      seq_err <= seq_bad;
      len_err <= len_bad;
      if (accept) begin
        beat_cnt <= beat_cnt + 64'd1;
        beats    <= cur_beats;
        if (is_hdr) begin
          exp_beats <= hdr_exp;
          exp_seq   <= hdr_seq + 12'd1;
          seq_valid <= 1'b1;
        end
        if (i_tlast) begin
          pkt_cnt <= pkt_cnt + 64'd1;
          state   <= S_HDR;
        end else begin
          state   <= S_BODY;
        end
      end
      if (seq_bad && seq_err_cnt != 32'hFFFF_FFFF)
        seq_err_cnt <= seq_err_cnt + 32'd1;
      if (len_bad && len_err_cnt != 32'hFFFF_FFFF)
        len_err_cnt <= len_err_cnt + 32'd1;
    end
  end

`ifdef NULL_SINK_CHECKER_TIMER_EN
  logic timer_run;

  // cycle timer: starts on first accepted beat after clear, holds while disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_run <= 1'b0;
      timer     <= 64'd0;
    end else if (clr) begin
      timer_run <= 1'b0;
      timer     <= 64'd0;
    end else begin
      if (accept) timer_run <= 1'b1;
      if ((timer_run | accept) & enable) timer <= timer + 64'd1;
    end
  end
`else
  assign timer = 64'd0;
`endif

  // registered readback mux
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rb_data <= 64'd0;
    end else begin
      unique case (rb_addr)
        8'd0:    rb_data <= pkt_cnt;
        8'd1:    rb_data <= beat_cnt;
        8'd2:    rb_data <= {seq_err_cnt, len_err_cnt};
        8'd3:    rb_data <= {status, exp_seq, rate};
        8'd4:    rb_data <= timer;
        default: rb_data <= 64'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_null_sink_checker.sv
// Directed bench for null_sink_checker.
// Checks counters, pulses, throttle, pause, async reset.
module tb_null_sink_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'd0;
  logic [31:0] set_data = 32'd0;
  logic [7:0]  rb_addr = 8'd0;
  logic [63:0] rb_data;
  logic [63:0] i_tdata = 64'd0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic        seq_err;
  logic        len_err;

  int vectors = 0;
  int miscompares = 0;
  int stalls = 0;
  int seq_p = 0;
  int len_p = 0;

  null_sink_checker dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .rb_addr  (rb_addr),
    .rb_data  (rb_data),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .seq_err  (seq_err),
    .len_err  (len_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (seq_err) seq_p++;
    if (len_err) len_p++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input logic [11:0] s,
                                      input logic [15:0] l);
    return {4'b0, s, l, 32'h0};
  endfunction

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1;
    set_addr = a;
    set_data = d;
    @(negedge clk);
    set_stb = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [63:0] v);
    rb_addr = a;
    @(negedge clk);
    v = rb_data;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l);
    int n;
    n = 0;
    i_tdata = d;
    i_tlast = l;
    i_tvalid = 1'b1;
    while (!i_tready && n < 200) begin
      @(negedge clk);
      n++;
      stalls++;
    end
    if (!i_tready) chk("tready_timeout", 64'd0, 64'd1);
    else @(negedge clk);
    i_tvalid = 1'b0;
    i_tlast = 1'b0;
  endtask

  task automatic send_pkt(input logic [11:0] s, input logic [15:0] l,
                          input int n);
    send_beat(hdr(s, l), n == 1);
    for (int i = 1; i < n; i++)
      send_beat(64'(i), i == n - 1);
  endtask

  initial begin
    logic [63:0] v;
    int sp0, lp0, highs, last_hi, cyc;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_tready", {63'd0, i_tready}, 64'd0);
    reset_n = 1'b1;
    rd(8'd0, v); chk("rst_pkt", v, 64'd0);
    rd(8'd1, v); chk("rst_beat", v, 64'd0);
    rd(8'd3, v); chk("rst_status", v, 64'd0);

    // 1: ten clean packets at full rate
    wr(8'd132, 32'd1);
    wr(8'd134, 32'd0);
    sp0 = seq_p; lp0 = len_p; stalls = 0;
    for (int p = 0; p < 10; p++) send_pkt(12'(p), 16'd64, 8);
    @(negedge clk);
    chk("t1_stalls", 64'(stalls), 64'd0);
    rd(8'd0, v); chk("t1_pkt", v, 64'd10);
    rd(8'd1, v); chk("t1_beat", v, 64'd80);
    rd(8'd2, v); chk("t1_errcnt", v, 64'd0);
    chk("t1_pulses", 64'(seq_p - sp0 + len_p - lp0), 64'd0);

    // 2: sequence wrap then a gap
    wr(8'd133, 32'd0);
    sp0 = seq_p;
    send_pkt(12'd4094, 16'd8, 1);
    send_pkt(12'd4095, 16'd8, 1);
    send_pkt(12'd0, 16'd8, 1);
    send_pkt(12'd1, 16'd8, 1);
    @(negedge clk);
    chk("t2_wrap_pulses", 64'(seq_p - sp0), 64'd0);
    send_pkt(12'd5, 16'd8, 1);
    @(negedge clk);
    chk("t2_gap_pulse", 64'(seq_p - sp0), 64'd1);
    rd(8'd2, v); chk("t2_gap_cnt", v, {32'd1, 32'd0});
    send_pkt(12'd6, 16'd8, 1);
    @(negedge clk);
    chk("t2_resync_pulse", 64'(seq_p - sp0), 64'd1);
    rd(8'd2, v); chk("t2_resync_cnt", v, {32'd1, 32'd0});
    rd(8'd3, v);
    chk("t2_status", v, {33'd0, 1'b1, 1'b0, 1'b1, 12'd7, 16'd0});
    rd(8'd0, v); chk("t2_pkt", v, 64'd6);

    // 3: length checks
    wr(8'd133, 32'd0);
    lp0 = len_p;
    send_pkt(12'd0, 16'd64, 6);
    @(negedge clk);
    chk("t3_short_pulse", 64'(len_p - lp0), 64'd1);
    rd(8'd2, v); chk("t3_short_cnt", v, {32'd0, 32'd1});
    send_pkt(12'd1, 16'd12, 2);
    send_pkt(12'd2, 16'd4, 1);
    @(negedge clk);
    chk("t3_ok_pulses", 64'(len_p - lp0), 64'd1);
    rd(8'd2, v); chk("t3_ok_cnt", v, {32'd0, 32'd1});
    rd(8'd1, v); chk("t3_beat", v, 64'd9);

    // 4: throttle N=3 with continuous tvalid
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wr(8'd134, 32'd3);
    i_tdata = hdr(12'd0, 16'd88);
    i_tlast = 1'b0;
    i_tvalid = 1'b1;
    highs = 0;
    last_hi = -1;
    cyc = 0;
    while (cyc < 40) begin
      if (i_tready) begin
        highs++;
        if (last_hi >= 0) chk("t4_gap", 64'(cyc - last_hi), 64'd4);
        last_hi = cyc;
        @(negedge clk);
        i_tdata = 64'hABCD;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    i_tvalid = 1'b0;
    chk("t4_highs", 64'(highs), 64'd10);
    rd(8'd1, v); chk("t4_beat", v, 64'd10);
    wr(8'd134, 32'd0);
    lp0 = len_p;
    send_beat(64'h1, 1'b1);
    @(negedge clk);
    rd(8'd0, v); chk("t4_pkt", v, 64'd1);
    chk("t4_len_ok", 64'(len_p - lp0), 64'd0);

    // 5: pause mid-packet
    wr(8'd133, 32'd0);
    sp0 = seq_p; lp0 = len_p;
    send_beat(hdr(12'd0, 16'd64), 1'b0);
    for (int i = 1; i < 4; i++) send_beat(64'(i), 1'b0);
    wr(8'd132, 32'd0);
    i_tvalid = 1'b1;
    i_tdata = 64'h4;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      if (i_tready) highs++;
      @(negedge clk);
    end
    i_tvalid = 1'b0;
    chk("t5_paused", 64'(highs), 64'd0);
    rd(8'd3, v);
    chk("t5_status", v, {33'd0, 1'b1, 1'b1, 1'b0, 12'd1, 16'd0});
    wr(8'd132, 32'd1);
    for (int i = 4; i < 8; i++) send_beat(64'(i), i == 7);
    @(negedge clk);
    rd(8'd0, v); chk("t5_pkt", v, 64'd1);
    rd(8'd1, v); chk("t5_beat", v, 64'd8);
    chk("t5_pulses", 64'(seq_p - sp0 + len_p - lp0), 64'd0);

    // 6: async reset mid-packet, right after a seq error
    rb_addr = 8'd1;
    send_beat(hdr(12'd5, 16'd64), 1'b0);
    chk("t6_pre_pulse", {63'd0, seq_err}, 64'd1);
    chk("t6_pre_rb", rb_data, 64'd8);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_tready", {63'd0, i_tready}, 64'd0);
    chk("t6_rst_rb", rb_data, 64'd0);
    chk("t6_rst_pulses", {62'd0, seq_err, len_err}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(8'd0, v); chk("t6_pkt", v, 64'd0);
    rd(8'd1, v); chk("t6_beat", v, 64'd0);
    rd(8'd2, v); chk("t6_err", v, 64'd0);
    rd(8'd3, v); chk("t6_status", v, 64'd0);

    // timer readback
    wr(8'd132, 32'd1);
    send_beat(hdr(12'd0, 16'd8), 1'b1);
    rb_addr = 8'd4;
    for (int i = 0; i < 99; i++) @(negedge clk);
    v = rb_data;
`ifdef NULL_SINK_CHECKER_TIMER_EN
    chk("timer_100", {63'd0, (v >= 64'd98 && v <= 64'd102)}, 64'd1);
`else
    chk("timer_absent", v, 64'd0);
`endif
    rd(8'd7, v); chk("rb_other", v, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
